// File: rtl/r5p_wbu_if.sv
// r5p_wbu_if: ALU, load, bus response, decode hazard and register file write port signals of the write-back unit
interface r5p_wbu_if #(
   parameter int AW   = 5,
   parameter int XLEN = 32
);
   logic            alu_vld;
   logic            alu_rdy;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_dat;
   logic            ld_req;
   logic            ld_rdy;
   logic [AW-1:0]   ld_rd;
   logic [2:0]      ld_fn3;
   logic [1:0]      ld_adr;
   logic            bus_rvld;
   logic [XLEN-1:0] bus_rdt;
   logic            e_rs1;
   logic            e_rs2;
   logic [AW-1:0]   a_rs1;
   logic [AW-1:0]   a_rs2;
   logic            stall;
   logic            ld_err;
   logic            e_rd;
   logic [AW-1:0]   a_rd;
   logic [XLEN-1:0] d_rd;
   modport slave (
      input  alu_vld, alu_rd, alu_dat, ld_req, ld_rd, ld_fn3, ld_adr, bus_rvld, bus_rdt,
             e_rs1, e_rs2, a_rs1, a_rs2,
      output alu_rdy, ld_rdy, stall, ld_err, e_rd, a_rd, d_rd
   );
   modport master (
      output alu_vld, alu_rd, alu_dat, ld_req, ld_rd, ld_fn3, ld_adr, bus_rvld, bus_rdt,
             e_rs1, e_rs2, a_rs1, a_rs2,
      input  alu_rdy, ld_rdy, stall, ld_err, e_rd, a_rd, d_rd
   );
endinterface

// File: rtl/r5p_wbu.sv
// r5p_wbu: write-back unit merging ALU results and aligned load data into the register file write port
module r5p_wbu #(
   parameter int AW   = 5,
   parameter int XLEN = 32,
   parameter bit WBYP = 1'b0
)(
   input logic    clk,
   input logic    rst,
   r5p_wbu_if.slave bus
);
   logic            pend;
   logic [AW-1:0]   pend_rd;
   logic [2:0]      pend_fn3;
   logic [1:0]      pend_adr;
   logic            done;
   logic            ld_rdy;
   logic            alu_rdy;
   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [XLEN-1:0] ld_dat;
   logic            e_rd;
   logic [AW-1:0]   a_rd;
   logic [XLEN-1:0] d_rd;
   logic            ld_err;
   logic            ld_haz;
   logic            wr_haz;
   assign done    = pend & bus.bus_rvld;
   assign ld_rdy  = ~pend | bus.bus_rvld;
   assign alu_rdy = ~done & ~(pend & (bus.alu_rd == pend_rd) & (|bus.alu_rd));
   assign ld_haz  = pend & (|pend_rd) &
                    ((bus.e_rs1 & (bus.a_rs1 == pend_rd)) | (bus.e_rs2 & (bus.a_rs2 == pend_rd)));
   assign wr_haz  = ~WBYP & e_rd & (|a_rd) &
                    ((bus.e_rs1 & (bus.a_rs1 == a_rd)) | (bus.e_rs2 & (bus.a_rs2 == a_rd)));
   assign bus.ld_rdy  = ld_rdy;
   assign bus.alu_rdy = alu_rdy;
   assign bus.stall   = ld_haz | wr_haz;
   assign bus.ld_err  = ld_err;
   assign bus.e_rd    = e_rd;
   assign bus.a_rd    = a_rd;
   assign bus.d_rd    = d_rd;
   // align and extend the returning load using the fields captured at issue
   always_comb begin
      ld_b   = bus.bus_rdt[8*pend_adr +: 8];
      ld_h   = bus.bus_rdt[16*pend_adr[1] +: 16];
      ld_dat = pend_fn3[1] ? bus.bus_rdt :
               pend_fn3[0] ? {{(XLEN-16){ld_h[15] & ~pend_fn3[2]}}, ld_h} :
                             {{(XLEN-8){ld_b[7] & ~pend_fn3[2]}}, ld_b};
   end
   // track the single outstanding load; a new issue on the completion cycle chains back-to-back
   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= 1'b0;
         pend_rd  <= '0;
         pend_fn3 <= '0;
         pend_adr <= '0;
      end else if (bus.ld_req & ld_rdy) begin
         pend     <= 1'b1;
         pend_rd  <= bus.ld_rd;
         pend_fn3 <= bus.ld_fn3;
         pend_adr <= bus.ld_adr;
      end else if (done) begin
         pend     <= 1'b0;
      end
   end
   // registered write port: load completion wins over the ALU, unsolicited responses only flag an error
   always_ff @(posedge clk) begin
      if (rst) begin
         e_rd   <= 1'b0;
         a_rd   <= '0;
         d_rd   <= '0;
         ld_err <= 1'b0;
      end else begin
         ld_err <= bus.bus_rvld & ~pend;
         e_rd   <= done | (bus.alu_vld & alu_rdy);
         if (done) begin
            a_rd <= pend_rd;
            d_rd <= ld_dat;
         end else if (bus.alu_vld & alu_rdy) begin
            a_rd <= bus.alu_rd;
            d_rd <= bus.alu_dat;
         end
      end
   end
endmodule

// File: tb/tb_r5p_wbu.sv
// tb_r5p_wbu: directed and randomized checks of r5p_wbu with and without register file write bypass
module tb_r5p_wbu;
   localparam int AW   = 5;
   localparam int XLEN = 32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   bit          m_pend, m_e, m_err;
   logic [4:0]  m_rd, m_a;
   logic [2:0]  m_fn3;
   logic [1:0]  m_adr;
   logic [31:0] m_d;
   bit          x_ld_rdy, x_alu_rdy, x_stall0, x_stall1;
   always #5 clk = ~clk;
   r5p_wbu_if #(.AW(AW), .XLEN(XLEN)) i0 ();
   r5p_wbu_if #(.AW(AW), .XLEN(XLEN)) i1 ();
   r5p_wbu #(.AW(AW), .XLEN(XLEN), .WBYP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
   r5p_wbu #(.AW(AW), .XLEN(XLEN), .WBYP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
   // second instance sees identical stimulus
   always_comb begin
      i1.alu_vld  = i0.alu_vld;
      i1.alu_rd   = i0.alu_rd;
      i1.alu_dat  = i0.alu_dat;
      i1.ld_req   = i0.ld_req;
      i1.ld_rd    = i0.ld_rd;
      i1.ld_fn3   = i0.ld_fn3;
      i1.ld_adr   = i0.ld_adr;
      i1.bus_rvld = i0.bus_rvld;
      i1.bus_rdt  = i0.bus_rdt;
      i1.e_rs1    = i0.e_rs1;
      i1.e_rs2    = i0.e_rs2;
      i1.a_rs1    = i0.a_rs1;
      i1.a_rs2    = i0.a_rs2;
   end

   function automatic logic [31:0] fmt(logic [2:0] f, logic [1:0] a, logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * (a / 2))) & 32'hFFFF;
      case (f)
         3'd0: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         3'd4: return b;
         3'd1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd5: return h;
         default: return w;
      endcase
   endfunction

   function automatic bit haz(logic [4:0] r);
      return (r != 0) && ((i0.e_rs1 && i0.a_rs1 == r) || (i0.e_rs2 && i0.a_rs2 == r));
   endfunction

   task automatic predict();
      x_ld_rdy  = !m_pend || i0.bus_rvld;
      x_alu_rdy = !(m_pend && i0.bus_rvld) && !(m_pend && i0.alu_rd == m_rd && i0.alu_rd != 0);
      x_stall1  = m_pend && haz(m_rd);
      x_stall0  = x_stall1 || (m_e && haz(m_a));
   endtask

   task automatic settle();
      #1;
      predict();
   endtask

   task automatic tick();
      bit done, acc, lda;
      predict();
      done = m_pend && i0.bus_rvld;
      acc  = i0.alu_vld && x_alu_rdy;
      lda  = i0.ld_req && x_ld_rdy;
      @(posedge clk);
      if (rst) begin
         m_pend = 0; m_e = 0; m_a = 0; m_d = 0; m_err = 0;
      end else begin
         m_err = i0.bus_rvld && !m_pend;
         m_e   = done || acc;
         if (done) begin
            m_a = m_rd;
            m_d = fmt(m_fn3, m_adr, i0.bus_rdt);
         end else if (acc) begin
            m_a = i0.alu_rd;
            m_d = i0.alu_dat;
         end
         if (lda) begin
            m_pend = 1; m_rd = i0.ld_rd; m_fn3 = i0.ld_fn3; m_adr = i0.ld_adr;
         end else if (done) m_pend = 0;
      end
      #1;
   endtask

   task automatic idle();
      i0.alu_vld = 0; i0.alu_rd = 0; i0.alu_dat = 0;
      i0.ld_req = 0; i0.ld_rd = 0; i0.ld_fn3 = 0; i0.ld_adr = 0;
      i0.bus_rvld = 0; i0.bus_rdt = 0;
      i0.e_rs1 = 0; i0.e_rs2 = 0; i0.a_rs1 = 0; i0.a_rs2 = 0;
   endtask

   task automatic issue(logic [4:0] rd, logic [2:0] f, logic [1:0] a);
      i0.ld_req = 1; i0.ld_rd = rd; i0.ld_fn3 = f; i0.ld_adr = a;
      tick();
      i0.ld_req = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick();
      tick();
      rst = 0;
      settle();
      checks++; if ({i0.e_rd, i0.a_rd, i0.d_rd, i0.ld_err} !== '0) begin errors++; $display("FAIL reset0 regs got e=%b a=%0d d=%h err=%b want 0", i0.e_rd, i0.a_rd, i0.d_rd, i0.ld_err); end
      checks++; if ({i1.e_rd, i1.a_rd, i1.d_rd, i1.ld_err} !== '0) begin errors++; $display("FAIL reset1 regs got e=%b a=%0d d=%h err=%b want 0", i1.e_rd, i1.a_rd, i1.d_rd, i1.ld_err); end
      checks++; if (i0.ld_rdy !== 1'b1 || i0.stall !== 1'b0) begin errors++; $display("FAIL reset ld_rdy/stall got %b/%b want 1/0", i0.ld_rdy, i0.stall); end
   endtask

   task automatic test_load_fmt();
      logic [2:0]  tf [9] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd4, 3'd1, 3'd6};
      logic [1:0]  ta [9] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd0};
      logic [31:0] tw [9] = '{32'h80AB_CDEF, 32'h80AB_CDEF, 32'h9234_5678, 32'h9234_5678, 32'hDEAD_BEEF,
                              32'h80AB_CDEF, 32'h80AB_CDEF, 32'h9234_5678, 32'h1357_9BDF};
      logic [31:0] te [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9234, 32'h0000_5678, 32'hDEAD_BEEF,
                              32'hFFFF_FFCD, 32'h0000_00EF, 32'hFFFF_9234, 32'h1357_9BDF};
      for (int k = 0; k < 9; k++) begin
         idle();
         issue(5'd3, tf[k], ta[k]);
         settle();
         checks++; if (i0.ld_rdy !== 1'b0) begin errors++; $display("FAIL fmt%0d ld_rdy pending got %b want 0", k, i0.ld_rdy); end
         i0.bus_rvld = 1; i0.bus_rdt = tw[k];
         settle();
         checks++; if (i0.ld_rdy !== 1'b1 || i0.alu_rdy !== 1'b0) begin errors++; $display("FAIL fmt%0d resp ld_rdy/alu_rdy got %b/%b want 1/0", k, i0.ld_rdy, i0.alu_rdy); end
         tick();
         i0.bus_rvld = 0;
         checks++; if (i0.e_rd !== 1'b1 || i0.a_rd !== 5'd3 || i0.d_rd !== te[k]) begin errors++; $display("FAIL fmt%0d write got e=%b a=%0d d=%h want 1/3/%h", k, i0.e_rd, i0.a_rd, i0.d_rd, te[k]); end
         checks++; if (i1.d_rd !== te[k]) begin errors++; $display("FAIL fmt%0d dut1 d_rd got %h want %h", k, i1.d_rd, te[k]); end
      end
   endtask

   task automatic test_stall();
      idle();
      issue(5'd5, 3'd2, 2'd0);
      i0.e_rs2 = 1; i0.a_rs2 = 5'd5;
      for (int k = 0; k < 2; k++) begin
         settle();
         checks++; if (i0.stall !== 1'b1 || i1.stall !== 1'b1) begin errors++; $display("FAIL stall pend%0d got %b/%b want 1/1", k, i0.stall, i1.stall); end
         tick();
      end
      i0.bus_rvld = 1; i0.bus_rdt = 32'h0000_1234;
      settle();
      checks++; if (i0.stall !== 1'b1 || i1.stall !== 1'b1) begin errors++; $display("FAIL stall resp got %b/%b want 1/1", i0.stall, i1.stall); end
      tick();
      i0.bus_rvld = 0;
      settle();
      checks++; if (i1.stall !== 1'b0) begin errors++; $display("FAIL stall bypass after got %b want 0", i1.stall); end
      checks++; if (i0.stall !== 1'b1 || i0.e_rd !== 1'b1 || i0.a_rd !== 5'd5) begin errors++; $display("FAIL stall nobypass after got s=%b e=%b a=%0d want 1/1/5", i0.stall, i0.e_rd, i0.a_rd); end
      tick();
      settle();
      checks++; if (i0.stall !== 1'b0) begin errors++; $display("FAIL stall nobypass clear got %b want 0", i0.stall); end
   endtask

   task automatic test_collide();
      idle();
      issue(5'd4, 3'd2, 2'd0);
      i0.bus_rvld = 1; i0.bus_rdt = 32'hCAFE_0001;
      i0.alu_vld = 1; i0.alu_rd = 5'd7; i0.alu_dat = 32'd42;
      settle();
      checks++; if (i0.alu_rdy !== 1'b0) begin errors++; $display("FAIL collide alu_rdy got %b want 0", i0.alu_rdy); end
      tick();
      i0.bus_rvld = 0;
      checks++; if (i0.e_rd !== 1'b1 || i0.a_rd !== 5'd4 || i0.d_rd !== 32'hCAFE_0001) begin errors++; $display("FAIL collide load got e=%b a=%0d d=%h want 1/4/cafe0001", i0.e_rd, i0.a_rd, i0.d_rd); end
      settle();
      checks++; if (i0.alu_rdy !== 1'b1) begin errors++; $display("FAIL collide alu_rdy2 got %b want 1", i0.alu_rdy); end
      tick();
      i0.alu_vld = 0;
      checks++; if (i0.e_rd !== 1'b1 || i0.a_rd !== 5'd7 || i0.d_rd !== 32'd42) begin errors++; $display("FAIL collide alu got e=%b a=%0d d=%h want 1/7/2a", i0.e_rd, i0.a_rd, i0.d_rd); end
   endtask

   task automatic test_waw();
      idle();
      issue(5'd9, 3'd2, 2'd0);
      i0.alu_vld = 1; i0.alu_rd = 5'd9; i0.alu_dat = 32'd42;
      for (int k = 0; k < 2; k++) begin
         settle();
         checks++; if (i0.alu_rdy !== 1'b0) begin errors++; $display("FAIL waw alu_rdy%0d got %b want 0", k, i0.alu_rdy); end
         tick();
         checks++; if (i0.e_rd !== 1'b0) begin errors++; $display("FAIL waw held%0d e_rd got %b want 0", k, i0.e_rd); end
      end
      i0.bus_rvld = 1; i0.bus_rdt = 32'h0BAD_F00D;
      tick();
      i0.bus_rvld = 0;
      checks++; if (i0.a_rd !== 5'd9 || i0.d_rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL waw first got a=%0d d=%h want 9/0badf00d", i0.a_rd, i0.d_rd); end
      tick();
      i0.alu_vld = 0;
      checks++; if (i0.e_rd !== 1'b1 || i0.a_rd !== 5'd9 || i0.d_rd !== 32'd42) begin errors++; $display("FAIL waw second got e=%b a=%0d d=%h want 1/9/2a", i0.e_rd, i0.a_rd, i0.d_rd); end
   endtask

   task automatic test_x0();
      idle();
      issue(5'd0, 3'd2, 2'd0);
      i0.e_rs1 = 1; i0.a_rs1 = 5'd0;
      i0.alu_vld = 1; i0.alu_rd = 5'd0; i0.alu_dat = 32'h55;
      settle();
      checks++; if (i0.stall !== 1'b0 || i1.stall !== 1'b0 || i0.alu_rdy !== 1'b1) begin errors++; $display("FAIL x0 stall/alu_rdy got %b/%b/%b want 0/0/1", i0.stall, i1.stall, i0.alu_rdy); end
      tick();
      i0.alu_vld = 0;
      settle();
      checks++; if (i0.e_rd !== 1'b1 || i0.a_rd !== 5'd0 || i0.stall !== 1'b0 || i0.ld_rdy !== 1'b0) begin errors++; $display("FAIL x0 alu write got e=%b a=%0d s=%b r=%b want 1/0/0/0", i0.e_rd, i0.a_rd, i0.stall, i0.ld_rdy); end
      i0.bus_rvld = 1; i0.bus_rdt = 32'h77;
      tick();
      i0.bus_rvld = 0;
      checks++; if (i0.e_rd !== 1'b1 || i0.d_rd !== 32'h77) begin errors++; $display("FAIL x0 load got e=%b d=%h want 1/77", i0.e_rd, i0.d_rd); end
   endtask

   task automatic test_unsolicited();
      idle();
      tick();
      i0.bus_rvld = 1; i0.bus_rdt = 32'h1111_2222;
      tick();
      i0.bus_rvld = 0;
      checks++; if (i0.ld_err !== 1'b1 || i0.e_rd !== 1'b0) begin errors++; $display("FAIL unsol err/e_rd got %b/%b want 1/0", i0.ld_err, i0.e_rd); end
      tick();
      checks++; if (i0.ld_err !== 1'b0) begin errors++; $display("FAIL unsol pulse width err got %b want 0", i0.ld_err); end
      issue(5'd6, 3'd2, 2'd0);
      rst = 1;
      tick();
      rst = 0;
      i0.bus_rvld = 1;
      settle();
      checks++; if (i0.ld_rdy !== 1'b1 || i0.alu_rdy !== 1'b1) begin errors++; $display("FAIL rstload rdy got %b/%b want 1/1", i0.ld_rdy, i0.alu_rdy); end
      tick();
      i0.bus_rvld = 0;
      checks++; if (i0.ld_err !== 1'b1 || i0.e_rd !== 1'b0) begin errors++; $display("FAIL rstload err/e_rd got %b/%b want 1/0", i0.ld_err, i0.e_rd); end
   endtask

   task automatic test_back_to_back();
      idle();
      issue(5'd1, 3'd2, 2'd0);
      i0.bus_rvld = 1; i0.bus_rdt = 32'hAAAA_0001;
      i0.ld_req = 1; i0.ld_rd = 5'd2; i0.ld_fn3 = 3'd4; i0.ld_adr = 2'd1;
      settle();
      checks++; if (i0.ld_rdy !== 1'b1) begin errors++; $display("FAIL b2b ld_rdy got %b want 1", i0.ld_rdy); end
      tick();
      i0.ld_req = 0; i0.bus_rvld = 0;
      settle();
      checks++; if (i0.a_rd !== 5'd1 || i0.d_rd !== 32'hAAAA_0001 || i0.ld_rdy !== 1'b0) begin errors++; $display("FAIL b2b first got a=%0d d=%h r=%b want 1/aaaa0001/0", i0.a_rd, i0.d_rd, i0.ld_rdy); end
      i0.bus_rvld = 1; i0.bus_rdt = 32'h0000_9A00;
      tick();
      i0.bus_rvld = 0;
      checks++; if (i0.e_rd !== 1'b1 || i0.a_rd !== 5'd2 || i0.d_rd !== 32'h9A) begin errors++; $display("FAIL b2b second got e=%b a=%0d d=%h want 1/2/9a", i0.e_rd, i0.a_rd, i0.d_rd); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rst         = ($urandom_range(0, 63) == 0);
         i0.bus_rvld = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         i0.ld_req   = (!m_pend || i0.bus_rvld) && ($urandom_range(0, 2) == 0);
         i0.ld_rd    = 5'($urandom_range(0, 7));
         i0.ld_fn3   = 3'($urandom_range(0, 7));
         i0.ld_adr   = 2'($urandom_range(0, 3));
         i0.bus_rdt  = $urandom;
         i0.alu_vld  = 1'($urandom_range(0, 1));
         i0.alu_rd   = 5'($urandom_range(0, 7));
         i0.alu_dat  = $urandom;
         i0.e_rs1    = 1'($urandom_range(0, 1));
         i0.e_rs2    = 1'($urandom_range(0, 1));
         i0.a_rs1    = 5'($urandom_range(0, 7));
         i0.a_rs2    = 5'($urandom_range(0, 7));
         settle();
         checks++; if ({i0.ld_rdy, i0.alu_rdy, i0.stall} !== {x_ld_rdy, x_alu_rdy, x_stall0}) begin errors++; $display("FAIL rnd%0d dut0 rdy/alu/stall got %b%b%b want %b%b%b", n, i0.ld_rdy, i0.alu_rdy, i0.stall, x_ld_rdy, x_alu_rdy, x_stall0); end
         checks++; if ({i1.ld_rdy, i1.alu_rdy, i1.stall} !== {x_ld_rdy, x_alu_rdy, x_stall1}) begin errors++; $display("FAIL rnd%0d dut1 rdy/alu/stall got %b%b%b want %b%b%b", n, i1.ld_rdy, i1.alu_rdy, i1.stall, x_ld_rdy, x_alu_rdy, x_stall1); end
         tick();
         checks++; if ({i0.e_rd, i0.a_rd, i0.d_rd, i0.ld_err} !== {m_e, m_a, m_d, m_err}) begin errors++; $display("FAIL rnd%0d dut0 e/a/d/err got %b/%0d/%h/%b want %b/%0d/%h/%b", n, i0.e_rd, i0.a_rd, i0.d_rd, i0.ld_err, m_e, m_a, m_d, m_err); end
         checks++; if ({i1.e_rd, i1.a_rd, i1.d_rd, i1.ld_err} !== {m_e, m_a, m_d, m_err}) begin errors++; $display("FAIL rnd%0d dut1 e/a/d/err got %b/%0d/%h/%b want %b/%0d/%h/%b", n, i1.e_rd, i1.a_rd, i1.d_rd, i1.ld_err, m_e, m_a, m_d, m_err); end
      end
      rst = 0;
   endtask

   initial begin
      idle();
      test_reset();
      test_load_fmt();
      test_stall();
      test_collide();
      test_waw();
      test_x0();
      test_unsolicited();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
